// File: rtl/qracc_array_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : qracc_array_sequencer
// Purpose  : Cycle sequencer for the QR compute-in-memory macro. Expands
//            single-beat write/read/compute commands into timed control
//            phases for the switch matrix, SRAM and column ADCs, captures
//            sense-amp or thermometer ADC results, and returns them through
//            a valid/ready response port.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, nrst                     clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake (ready only in IDLE)
//   cmd_mode                      00 write, 01 read, 10 compute, 11 illegal
//   cmd_addr, cmd_wdata, cmd_act  row address, write data, compute activations
//   rsp_valid/rsp_ready           response handshake
//   rsp_data, rsp_err, rsp_bubble response payload and status
//   vdr_sel, vss_sel, vrst_sel,wl row controls (+ *_selb complements)
//   pch, write, saen, nf, m2a, r2a SRAM / ADC strobes (+ nfb, m2ab, r2ab)
//   wr_data, csel                 column write data and column select
//   sa_out, adc_out               sense-amp and thermometer ADC results
// ============================================================================
module qracc_array_sequencer #(
  parameter int NUM_ROWS   = 128,
  parameter int NUM_COLS   = 32,
  parameter int COMP_COUNT = 7,
  parameter int ADC_BITS   = $clog2(COMP_COUNT + 1),
  parameter int T_RST      = 2,
  parameter int T_PCH      = 2,
  parameter int T_SETTLE   = 3
) (
  input  logic                           clk,
  input  logic                           nrst,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [1:0]                     cmd_mode,
  input  logic [$clog2(NUM_ROWS)-1:0]    cmd_addr,
  input  logic [NUM_COLS-1:0]            cmd_wdata,
  input  logic [NUM_ROWS-1:0]            cmd_act,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [NUM_COLS*ADC_BITS-1:0]   rsp_data,
  output logic                           rsp_err,
  output logic                           rsp_bubble,
  output logic [NUM_ROWS-1:0]            vdr_sel,
  output logic [NUM_ROWS-1:0]            vss_sel,
  output logic [NUM_ROWS-1:0]            vrst_sel,
  output logic [NUM_ROWS-1:0]            wl,
  output logic [NUM_ROWS-1:0]            vdr_selb,
  output logic [NUM_ROWS-1:0]            vss_selb,
  output logic [NUM_ROWS-1:0]            vrst_selb,
  output logic                           pch,
  output logic                           write,
  output logic                           saen,
  output logic                           nf,
  output logic                           m2a,
  output logic                           r2a,
  output logic                           nfb,
  output logic                           m2ab,
  output logic                           r2ab,
  output logic [NUM_COLS-1:0]            wr_data,
  output logic [NUM_COLS-1:0]            csel,
  input  logic [NUM_COLS-1:0]            sa_out,
  input  logic [COMP_COUNT*NUM_COLS-1:0] adc_out
);

  localparam int RSP_W = NUM_COLS * ADC_BITS;
  localparam int CNT_W = 16;

  localparam logic [1:0] MODE_WRITE   = 2'b00;
  localparam logic [1:0] MODE_READ    = 2'b01;
  localparam logic [1:0] MODE_COMPUTE = 2'b10;
  localparam logic [1:0] MODE_ILLEGAL = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_PCH     = 4'd1,
    S_WRITE   = 4'd2,
    S_WL      = 4'd3,
    S_SENSE   = 4'd4,
    S_RST     = 4'd5,
    S_DRIVE   = 4'd6,
    S_NF      = 4'd7,
    S_M2A     = 4'd8,
    S_R2A     = 4'd9,
    S_CAPTURE = 4'd10,
    S_RESP    = 4'd11
  } state_t;

  state_t                       state;
  logic [CNT_W-1:0]             cnt;
  logic [1:0]                   mode_q;
  logic [$clog2(NUM_ROWS)-1:0]  addr_q;
  logic [NUM_COLS-1:0]          data_q;
  logic [NUM_ROWS-1:0]          act_q;

  logic                         addr_oob;
  logic                         cmd_bad;
  logic [NUM_ROWS-1:0]          row_onehot;
  logic [RSP_W-1:0]             adc_bin;
  logic [NUM_COLS-1:0]          col_bubble;
  logic                         cnt_done;

  assign cmd_ready  = (state == S_IDLE);
  assign cnt_done   = (cnt == '0);
  assign addr_oob   = (32'(cmd_addr) >= 32'(NUM_ROWS));
  // Address range only matters for row-addressed commands; compute ignores it.
  assign cmd_bad    = (cmd_mode == MODE_ILLEGAL) || (!cmd_mode[1] && addr_oob);
  assign row_onehot = NUM_ROWS'(1) << addr_q;

  // Complements are taken straight off the true-polarity flops so the pair
  // can never disagree in any cycle, including during reset.
  assign vdr_selb  = ~vdr_sel;
  assign vss_selb  = ~vss_sel;
  assign vrst_selb = ~vrst_sel;
  assign nfb       = ~nf;
  assign m2ab      = ~m2a;
  assign r2ab      = ~r2a;

  // Thermometer-to-binary per column. A code is monotonic exactly when
  // code+1 is a power of two, i.e. code & (code+1) == 0.
  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    logic [COMP_COUNT-1:0] therm;
    logic [COMP_COUNT:0]   therm_ext;
    logic [ADC_BITS-1:0]   ones;

    assign therm          = adc_out[c*COMP_COUNT +: COMP_COUNT];
    assign therm_ext      = {1'b0, therm};
    assign col_bubble[c]  = |(therm_ext & (therm_ext + (COMP_COUNT+1)'(1)));

    always_comb begin
      ones = '0;
      for (int i = 0; i < COMP_COUNT; i++) begin
        ones = ones + ADC_BITS'(therm[i]);
      end
    end

    assign adc_bin[c*ADC_BITS +: ADC_BITS] = ones;
  end

  // Outputs are loaded on the edge that enters a phase, so each strobe is
  // high for exactly the cycles its phase occupies.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      mode_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      act_q      <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      rsp_bubble <= 1'b0;
      vdr_sel    <= '0;
      vss_sel    <= '0;
      vrst_sel   <= '0;
      wl         <= '0;
      pch        <= 1'b0;
      write      <= 1'b0;
      saen       <= 1'b0;
      nf         <= 1'b0;
      m2a        <= 1'b0;
      r2a        <= 1'b0;
      wr_data    <= '0;
      csel       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            mode_q <= cmd_mode;
            addr_q <= cmd_addr;
            data_q <= cmd_wdata;
            act_q  <= cmd_act;
            if (cmd_bad) begin
              state      <= S_RESP;
              rsp_valid  <= 1'b1;
              rsp_err    <= 1'b1;
              rsp_data   <= '0;
              rsp_bubble <= 1'b0;
            end else if (cmd_mode == MODE_COMPUTE) begin
              state    <= S_RST;
              cnt      <= CNT_W'(T_RST - 1);
              vrst_sel <= '1;
            end else begin
              state <= S_PCH;
              cnt   <= CNT_W'(T_PCH - 1);
              pch   <= 1'b1;
            end
          end
        end

        S_PCH: begin
          if (cnt_done) begin
            pch <= 1'b0;
            wl  <= row_onehot;
            cnt <= CNT_W'(T_SETTLE - 1);
            if (mode_q == MODE_WRITE) begin
              state   <= S_WRITE;
              write   <= 1'b1;
              wr_data <= data_q;
              csel    <= '1;
            end else begin
              state <= S_WL;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        S_WRITE: begin
          if (cnt_done) begin
            state      <= S_RESP;
            wl         <= '0;
            write      <= 1'b0;
            wr_data    <= '0;
            csel       <= '0;
            rsp_valid  <= 1'b1;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            rsp_bubble <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        S_WL: begin
          if (cnt_done) begin
            state <= S_SENSE;
            wl    <= '0;
            saen  <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        S_SENSE: begin
          state      <= S_RESP;
          saen       <= 1'b0;
          rsp_valid  <= 1'b1;
          rsp_data   <= RSP_W'(sa_out);
          rsp_err    <= 1'b0;
          rsp_bubble <= 1'b0;
        end

        S_RST: begin
          if (cnt_done) begin
            state    <= S_DRIVE;
            cnt      <= CNT_W'(T_SETTLE - 1);
            vrst_sel <= '0;
            vdr_sel  <= act_q;
            vss_sel  <= ~act_q;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        S_DRIVE: begin
          if (cnt_done) begin
            state <= S_NF;
            cnt   <= CNT_W'(T_SETTLE - 1);
            nf    <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        S_NF: begin
          if (cnt_done) begin
            state <= S_M2A;
            cnt   <= CNT_W'(T_SETTLE - 1);
            nf    <= 1'b0;
            m2a   <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        S_M2A: begin
          if (cnt_done) begin
            state <= S_R2A;
            cnt   <= CNT_W'(T_SETTLE - 1);
            m2a   <= 1'b0;
            r2a   <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        S_R2A: begin
          if (cnt_done) begin
            state   <= S_CAPTURE;
            r2a     <= 1'b0;
            vdr_sel <= '0;
            vss_sel <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        S_CAPTURE: begin
          state      <= S_RESP;
          rsp_valid  <= 1'b1;
          rsp_data   <= adc_bin;
          rsp_err    <= 1'b0;
          rsp_bubble <= |col_bubble;
        end

        S_RESP: begin
          if (rsp_ready) begin
            state      <= S_IDLE;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            rsp_bubble <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qracc_array_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_qracc_array_sequencer
// Purpose  : Directed self-checking bench for qracc_array_sequencer. One
//            default-sized instance covers write/read/compute/reset; a second
//            instance with NUM_ROWS=100 covers the error responses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qracc_array_sequencer;

  logic          clk;
  logic          nrst;
  int            checks;
  int            errors;

  // ---------------- default instance ----------------
  logic          cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err, rsp_bubble;
  logic [1:0]    cmd_mode;
  logic [6:0]    cmd_addr;
  logic [31:0]   cmd_wdata, sa_out, wr_data, csel;
  logic [127:0]  cmd_act;
  logic [95:0]   rsp_data;
  logic [223:0]  adc_out;
  logic [127:0]  vdr_sel, vss_sel, vrst_sel, wl, vdr_selb, vss_selb, vrst_selb;
  logic          pch, write, saen, nf, m2a, r2a, nfb, m2ab, r2ab;

  // ---------------- NUM_ROWS=100 instance ----------------
  logic          e_cmd_valid, e_cmd_ready, e_rsp_valid, e_rsp_ready, e_rsp_err, e_rsp_bubble;
  logic [1:0]    e_cmd_mode;
  logic [6:0]    e_cmd_addr;
  logic [99:0]   e_cmd_act;
  logic [95:0]   e_rsp_data;
  logic [31:0]   e_wr_data, e_csel;
  logic [99:0]   e_vdr_sel, e_vss_sel, e_vrst_sel, e_wl, e_vdr_selb, e_vss_selb, e_vrst_selb;
  logic          e_pch, e_write, e_saen, e_nf, e_m2a, e_r2a, e_nfb, e_m2ab, e_r2ab;
  logic          e_active, e_idle_b;

  assign e_active = |{e_vdr_sel, e_vss_sel, e_vrst_sel, e_wl, e_pch, e_write,
                      e_saen, e_nf, e_m2a, e_r2a, e_wr_data, e_csel};
  assign e_idle_b = &{e_vdr_selb, e_vss_selb, e_vrst_selb, e_nfb, e_m2ab, e_r2ab};

  qracc_array_sequencer dut (
    .clk(clk), .nrst(nrst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_act(cmd_act),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_bubble(rsp_bubble),
    .vdr_sel(vdr_sel), .vss_sel(vss_sel), .vrst_sel(vrst_sel), .wl(wl),
    .vdr_selb(vdr_selb), .vss_selb(vss_selb), .vrst_selb(vrst_selb),
    .pch(pch), .write(write), .saen(saen), .nf(nf), .m2a(m2a), .r2a(r2a),
    .nfb(nfb), .m2ab(m2ab), .r2ab(r2ab),
    .wr_data(wr_data), .csel(csel), .sa_out(sa_out), .adc_out(adc_out)
  );

  qracc_array_sequencer #(.NUM_ROWS(100)) dut_err (
    .clk(clk), .nrst(nrst),
    .cmd_valid(e_cmd_valid), .cmd_ready(e_cmd_ready), .cmd_mode(e_cmd_mode),
    .cmd_addr(e_cmd_addr), .cmd_wdata(cmd_wdata), .cmd_act(e_cmd_act),
    .rsp_valid(e_rsp_valid), .rsp_ready(e_rsp_ready), .rsp_data(e_rsp_data),
    .rsp_err(e_rsp_err), .rsp_bubble(e_rsp_bubble),
    .vdr_sel(e_vdr_sel), .vss_sel(e_vss_sel), .vrst_sel(e_vrst_sel), .wl(e_wl),
    .vdr_selb(e_vdr_selb), .vss_selb(e_vss_selb), .vrst_selb(e_vrst_selb),
    .pch(e_pch), .write(e_write), .saen(e_saen), .nf(e_nf), .m2a(e_m2a), .r2a(e_r2a),
    .nfb(e_nfb), .m2ab(e_m2ab), .r2ab(e_r2ab),
    .wr_data(e_wr_data), .csel(e_csel), .sa_out(sa_out), .adc_out(adc_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int cyc,
                       input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of cycle 1.
  task automatic send(input logic [1:0] m, input logic [6:0] a);
    cmd_mode  = m;
    cmd_addr  = a;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic accept_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [127:0] act_pat;
    logic [127:0] ev;
    logic [127:0] es;
    logic         en;

    checks = 0;
    errors = 0;
    act_pat = {64{2'b01}};
    nrst = 1'b0;
    cmd_valid = 1'b0; cmd_mode = 2'b00; cmd_addr = '0; cmd_wdata = '0;
    cmd_act = '0; rsp_ready = 1'b0; sa_out = '0; adc_out = '0;
    e_cmd_valid = 1'b0; e_cmd_mode = 2'b00; e_cmd_addr = '0; e_cmd_act = '0;
    e_rsp_ready = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 0, 128'(cmd_ready), 128'(1));
    check("rst_rsp_valid", 0, 128'(rsp_valid), 128'(0));
    check("rst_pch",       0, 128'(pch), 128'(0));
    check("rst_wl",        0, wl, 128'(0));
    check("rst_vdr_selb",  0, vdr_selb, {128{1'b1}});
    check("rst_strobe_b",  0, 128'({nfb, m2ab, r2ab}), 128'(3'b111));
    check("rst_e_active",  0, 128'(e_active), 128'(0));
    nrst = 1'b1;
    @(negedge clk);

    // ---------------- write addr 5 ----------------
    cmd_wdata = 32'hA5A5A5A5;
    send(2'b00, 7'd5);
    for (int c = 1; c <= 6; c++) begin
      en = (c >= 3 && c <= 5);
      check("wr_pch",       c, 128'(pch), 128'(c <= 2));
      check("wr_write",     c, 128'(write), 128'(en));
      check("wr_wl",        c, wl, en ? (128'(1) << 5) : 128'd0);
      check("wr_data",      c, 128'(wr_data), en ? 128'(32'hA5A5A5A5) : 128'd0);
      check("wr_csel",      c, 128'(csel), en ? 128'(32'hFFFFFFFF) : 128'd0);
      check("wr_vdr_selb",  c, vdr_selb, {128{1'b1}});
      check("wr_rsp_valid", c, 128'(rsp_valid), 128'(c == 6));
      check("wr_cmd_ready", c, 128'(cmd_ready), 128'(0));
      if (c < 6) @(negedge clk);
    end
    check("wr_rsp_data", 6, 128'(rsp_data), 128'd0);
    check("wr_rsp_err",  6, 128'(rsp_err), 128'd0);
    accept_rsp();
    check("wr_idle_ready", 7, 128'(cmd_ready), 128'(1));
    check("wr_idle_valid", 7, 128'(rsp_valid), 128'(0));

    // ---------------- read addr 127 ----------------
    sa_out = 32'h0F0F0F0F;
    send(2'b01, 7'd127);
    for (int c = 1; c <= 7; c++) begin
      check("rd_pch",       c, 128'(pch), 128'(c <= 2));
      check("rd_wl",        c, wl, (c >= 3 && c <= 5) ? (128'(1) << 127) : 128'd0);
      check("rd_saen",      c, 128'(saen), 128'(c == 6));
      check("rd_write",     c, 128'(write), 128'(0));
      check("rd_rsp_valid", c, 128'(rsp_valid), 128'(c == 7));
      if (c < 7) @(negedge clk);
    end
    check("rd_rsp_data", 7, 128'(rsp_data), 128'(32'h0F0F0F0F));
    check("rd_rsp_err",  7, 128'(rsp_err), 128'd0);
    accept_rsp();

    // ---------------- compute, column 3 = 0011111 ----------------
    cmd_act = act_pat;
    adc_out = '0;
    adc_out[27:21] = 7'b0011111;
    send(2'b10, 7'd0);
    for (int c = 1; c <= 16; c++) begin
      ev = (c >= 3 && c <= 14) ? act_pat : 128'd0;
      es = (c >= 3 && c <= 14) ? ~act_pat : 128'd0;
      check("cp_vrst",      c, vrst_sel, (c <= 2) ? {128{1'b1}} : 128'd0);
      check("cp_vrst_b",    c, vrst_selb, (c <= 2) ? 128'd0 : {128{1'b1}});
      check("cp_vdr",       c, vdr_sel, ev);
      check("cp_vdr_b",     c, vdr_selb, ~ev);
      check("cp_vss",       c, vss_sel, es);
      check("cp_nf",        c, 128'(nf), 128'(c >= 6 && c <= 8));
      check("cp_nfb",       c, 128'(nfb), 128'(!(c >= 6 && c <= 8)));
      check("cp_m2a",       c, 128'(m2a), 128'(c >= 9 && c <= 11));
      check("cp_r2a",       c, 128'(r2a), 128'(c >= 12 && c <= 14));
      check("cp_rsp_valid", c, 128'(rsp_valid), 128'(c == 16));
      if (c < 16) @(negedge clk);
    end
    check("cp_rsp_data",   16, 128'(rsp_data), 128'(96'h0A00));
    check("cp_rsp_bubble", 16, 128'(rsp_bubble), 128'd0);
    check("cp_rsp_err",    16, 128'(rsp_err), 128'd0);
    accept_rsp();

    // ---------------- compute, column 0 = 1010000 (bubble) ----------------
    adc_out = '0;
    adc_out[6:0] = 7'b1010000;
    send(2'b10, 7'd0);
    for (int c = 1; c <= 16; c++) begin
      check("cb_rsp_valid", c, 128'(rsp_valid), 128'(c == 16));
      if (c < 16) @(negedge clk);
    end
    check("cb_rsp_data",   16, 128'(rsp_data), 128'd2);
    check("cb_rsp_bubble", 16, 128'(rsp_bubble), 128'd1);
    accept_rsp();
    check("cb_bubble_clr", 17, 128'(rsp_bubble), 128'd0);

    // ---------------- illegal mode on NUM_ROWS=100 instance ----------------
    e_cmd_mode  = 2'b11;
    e_cmd_valid = 1'b1;
    @(negedge clk);
    e_cmd_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      check("il_rsp_valid", c, 128'(e_rsp_valid), 128'd1);
      check("il_rsp_err",   c, 128'(e_rsp_err), 128'd1);
      check("il_rsp_data",  c, 128'(e_rsp_data), 128'd0);
      check("il_cmd_ready", c, 128'(e_cmd_ready), 128'd0);
      check("il_active",    c, 128'(e_active), 128'd0);
      check("il_idle_b",    c, 128'(e_idle_b), 128'd1);
      @(negedge clk);
    end
    e_rsp_ready = 1'b1;
    @(negedge clk);
    e_rsp_ready = 1'b0;
    check("il_cmd_ready_after", 0, 128'(e_cmd_ready), 128'd1);
    check("il_rsp_err_after",   0, 128'(e_rsp_err), 128'd0);

    // ---------------- read addr 120 >= NUM_ROWS ----------------
    e_cmd_mode  = 2'b01;
    e_cmd_addr  = 7'd120;
    e_cmd_valid = 1'b1;
    @(negedge clk);
    e_cmd_valid = 1'b0;
    check("oob_rsp_valid", 1, 128'(e_rsp_valid), 128'd1);
    check("oob_rsp_err",   1, 128'(e_rsp_err), 128'd1);
    check("oob_rsp_data",  1, 128'(e_rsp_data), 128'd0);
    check("oob_active",    1, 128'(e_active), 128'd0);
    e_rsp_ready = 1'b1;
    @(negedge clk);
    e_rsp_ready = 1'b0;
    check("oob_active_after", 2, 128'(e_active), 128'd0);

    // ---------------- reset during compute DRIVE ----------------
    cmd_act = act_pat;
    send(2'b10, 7'd0);
    repeat (3) @(negedge clk);
    check("ar_in_drive", 4, vdr_sel, act_pat);
    nrst = 1'b0;
    #1;
    check("ar_vdr_sel",   4, vdr_sel, 128'd0);
    check("ar_vss_sel",   4, vss_sel, 128'd0);
    check("ar_vdr_selb",  4, vdr_selb, {128{1'b1}});
    check("ar_vss_selb",  4, vss_selb, {128{1'b1}});
    check("ar_cmd_ready", 4, 128'(cmd_ready), 128'd1);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    check("ar_ready_after", 0, 128'(cmd_ready), 128'd1);
    check("ar_no_rsp",      0, 128'(rsp_valid), 128'd0);

    cmd_wdata = 32'h12345678;
    send(2'b00, 7'd5);
    for (int c = 1; c <= 6; c++) begin
      check("aw_wl",        c, wl, (c >= 3 && c <= 5) ? (128'(1) << 5) : 128'd0);
      check("aw_rsp_valid", c, 128'(rsp_valid), 128'(c == 6));
      if (c < 6) @(negedge clk);
    end
    check("aw_rsp_data", 6, 128'(rsp_data), 128'd0);
    check("aw_rsp_err",  6, 128'(rsp_err), 128'd0);
    accept_rsp();
    check("aw_idle", 7, 128'(cmd_ready), 128'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
